// File: rtl/wt8_err_accum.sv
// rtl/wt8_err_accum.sv - windowed error-metric accumulator for approximate vs exact products
// Optional sum-of-squared-error output enabled by defining WT8_ERR_ACCUM_SQ_ERR_EN.
module wt8_err_accum #(
    parameter int W        = 16,
    parameter int WIN_LOG2 = 10,
    parameter int ACC_W    = W + WIN_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        prod_apx,
    input  logic [W-1:0]        prod_ref,
    input  logic                flush,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    sum_abs_err,
    output logic [W-1:0]        max_abs_err,
    output logic [WIN_LOG2:0]   err_count,
    output logic [WIN_LOG2:0]   n_samples
`ifdef WT8_ERR_ACCUM_SQ_ERR_EN
    ,
    output logic [2*W+WIN_LOG2-1:0] sum_sq_err
`endif
);

    localparam int N_W = WIN_LOG2 + 1;
    localparam logic [N_W-1:0] WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0] acc_sum_q, acc_sum_d, acc_sum_nx;
    logic [W-1:0]     acc_max_q, acc_max_d, acc_max_nx;
    logic [N_W-1:0]   acc_cnt_q, acc_cnt_d, acc_cnt_nx;
    logic [N_W-1:0]   n_q, n_d, n_nx;

    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [W-1:0]     out_max_q, out_max_d;
    logic [N_W-1:0]   out_cnt_q, out_cnt_d;
    logic [N_W-1:0]   out_n_q, out_n_d;

    logic             accept;
    logic             close;
    logic [W:0]       diff;
    logic [W-1:0]     abs_err;

    assign in_ready = (state_q == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;

    // Magnitude of a negative (W+1)-bit difference never exceeds 2^W-1, so
    // negating the low W bits alone gives the exact absolute value.
    always_comb begin
        diff    = {1'b0, prod_apx} - {1'b0, prod_ref};
        abs_err = diff[W] ? ({W{1'b0}} - diff[W-1:0]) : diff[W-1:0];
    end

    always_comb begin
        acc_sum_nx = acc_sum_q;
        acc_max_nx = acc_max_q;
        acc_cnt_nx = acc_cnt_q;
        n_nx       = n_q;
        if (accept) begin
            acc_sum_nx = acc_sum_q + ACC_W'(abs_err);
            acc_max_nx = (abs_err > acc_max_q) ? abs_err : acc_max_q;
            acc_cnt_nx = acc_cnt_q + N_W'(abs_err != '0);
            n_nx       = n_q + N_W'(1'b1);
        end
    end

    assign close = (state_q == ACCUM) && ((accept && (n_nx == WIN_LEN)) || flush);

    always_comb begin
        state_d   = state_q;
        acc_sum_d = acc_sum_nx;
        acc_max_d = acc_max_nx;
        acc_cnt_d = acc_cnt_nx;
        n_d       = n_nx;
        out_sum_d = out_sum_q;
        out_max_d = out_max_q;
        out_cnt_d = out_cnt_q;
        out_n_d   = out_n_q;
        case (state_q)
            ACCUM: begin
                if (close) begin
                    state_d   = HOLD;
                    out_sum_d = acc_sum_nx;
                    out_max_d = acc_max_nx;
                    out_cnt_d = acc_cnt_nx;
                    out_n_d   = n_nx;
                    acc_sum_d = '0;
                    acc_max_d = '0;
                    acc_cnt_d = '0;
                    n_d       = '0;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_sum_q <= '0;
            acc_max_q <= '0;
            acc_cnt_q <= '0;
            n_q       <= '0;
            out_sum_q <= '0;
            out_max_q <= '0;
            out_cnt_q <= '0;
            out_n_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_sum_q <= acc_sum_d;
            acc_max_q <= acc_max_d;
            acc_cnt_q <= acc_cnt_d;
            n_q       <= n_d;
            out_sum_q <= out_sum_d;
            out_max_q <= out_max_d;
            out_cnt_q <= out_cnt_d;
            out_n_q   <= out_n_d;
        end
    end

`ifdef WT8_ERR_ACCUM_SQ_ERR_EN
    localparam int SQ_W = 2 * W + WIN_LOG2;

    logic [SQ_W-1:0] acc_sq_q, acc_sq_d, acc_sq_nx;
    logic [SQ_W-1:0] out_sq_q, out_sq_d;

    always_comb begin
        acc_sq_nx = accept ? (acc_sq_q + SQ_W'(abs_err) * SQ_W'(abs_err)) : acc_sq_q;
        acc_sq_d  = close ? '0 : acc_sq_nx;
        out_sq_d  = close ? acc_sq_nx : out_sq_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sq_q <= '0;
            out_sq_q <= '0;
        end else begin
            acc_sq_q <= acc_sq_d;
            out_sq_q <= out_sq_d;
        end
    end

    assign sum_sq_err = out_sq_q;
`endif

    assign res_valid   = (state_q == HOLD);
    assign sum_abs_err = out_sum_q;
    assign max_abs_err = out_max_q;
    assign err_count   = out_cnt_q;
    assign n_samples   = out_n_q;

endmodule

// File: tb/tb_wt8_err_accum.sv
// tb/tb_wt8_err_accum.sv - self-checking bench for wt8_err_accum (W=16, window of 4)
module tb_wt8_err_accum;

    localparam int W     = 16;
    localparam int WL    = 2;
    localparam int ACC_W = W + WL;
    localparam int WIN   = 4;
`ifdef WT8_ERR_ACCUM_SQ_ERR_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] sum;
        logic [63:0] mx;
        logic [63:0] cnt;
        logic [63:0] n;
        logic [63:0] sq;
    } rec_t;

    logic clk = 1'b0;
    logic rst, in_valid, flush, res_ready;
    logic [W-1:0] prod_apx, prod_ref;
    logic in_ready, res_valid;
    logic [ACC_W-1:0] sum_abs_err;
    logic [W-1:0] max_abs_err;
    logic [WL:0] err_count, n_samples;
    logic [63:0] d_sq;
    rec_t dut_rec;

    int checks = 0;
    int failures = 0;
    longint unsigned win_q[$];

    always #5 clk = ~clk;

`ifdef WT8_ERR_ACCUM_SQ_ERR_EN
    logic [2*W+WL-1:0] sum_sq_err;
    assign d_sq = 64'(sum_sq_err);
`else
    assign d_sq = '0;
`endif
    assign dut_rec = '{sum: 64'(sum_abs_err), mx: 64'(max_abs_err), cnt: 64'(err_count),
                       n: 64'(n_samples), sq: d_sq};

    wt8_err_accum #(.W(W), .WIN_LOG2(WL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .prod_apx(prod_apx), .prod_ref(prod_ref), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready),
        .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
        .err_count(err_count), .n_samples(n_samples)
`ifdef WT8_ERR_ACCUM_SQ_ERR_EN
        , .sum_sq_err(sum_sq_err)
`endif
    );

    function automatic longint unsigned abs_diff(input longint unsigned a, input longint unsigned b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Window metrics straight from their definitions over the list of errors.
    function automatic rec_t summarize();
        rec_t r;
        r = '0;
        foreach (win_q[i]) begin
            r.sum += win_q[i];
            if (win_q[i] > r.mx) r.mx = win_q[i];
            if (win_q[i] != 0) r.cnt += 1;
            r.n += 1;
            if (SQ_EN) r.sq += win_q[i] * win_q[i];
        end
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
        prod_apx = '0; prod_ref = '0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0 || dut_rec !== '0) begin
            failures++;
            $display("FAIL reset_state in_ready=%b res_valid=%b rec=%h required 0,0,0", in_ready, res_valid, dut_rec);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b res_valid=%b required 1,0", in_ready, res_valid);
        end
    endtask

    task automatic test_basic_backpressure();
        logic [W-1:0] apx [4] = '{16'd100, 16'd50, 16'd7, 16'd65535};
        logic [W-1:0] rf  [4] = '{16'd100, 16'd60, 16'd3, 16'd0};
        rec_t e;
        e = '{sum: 64'd65549, mx: 64'd65535, cnt: 64'd3, n: 64'd4,
              sq: SQ_EN ? 64'd4294836341 : 64'd0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL basic_in_ready[%0d] got=%b required=1", i, in_ready);
            end
            in_valid = 1'b1; prod_apx = apx[i]; prod_ref = rf[i];
            @(negedge clk);
        end
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || dut_rec !== e) begin
                failures++;
                $display("FAIL basic_hold[%0d] res_valid=%b in_ready=%b rec=%h required 1,0,%h", c, res_valid, in_ready, dut_rec, e);
            end
            in_valid = (c < 5);
            prod_apx = W'($urandom); prod_ref = W'($urandom);
            if (c < 5) @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || dut_rec !== e) begin
            failures++;
            $display("FAIL basic_release res_valid=%b in_ready=%b rec=%h required 0,1,%h", res_valid, in_ready, dut_rec, e);
        end
    endtask

    task automatic test_flush();
        rec_t e;
        in_valid = 1'b1; prod_apx = 16'd10; prod_ref = 16'd12;
        @(negedge clk);
        prod_apx = 16'd9; prod_ref = 16'd9;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        e = '{sum: 64'd2, mx: 64'd2, cnt: 64'd1, n: 64'd2, sq: SQ_EN ? 64'd4 : 64'd0};
        checks++;
        if (res_valid !== 1'b1 || dut_rec !== e) begin
            failures++;
            $display("FAIL flush_partial res_valid=%b rec=%h required 1,%h", res_valid, dut_rec, e);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || dut_rec !== '0) begin
            failures++;
            $display("FAIL flush_empty res_valid=%b rec=%h required 1,0", res_valid, dut_rec);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_flush_coincident();
        rec_t e;
        win_q.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; prod_apx = W'($urandom); prod_ref = W'($urandom);
            flush = (i == 3);
            win_q.push_back(abs_diff(prod_apx, prod_ref));
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0;
        e = summarize();
        checks++;
        if (res_valid !== 1'b1 || dut_rec !== e) begin
            failures++;
            $display("FAIL flush_coincident res_valid=%b rec=%h required 1,%h", res_valid, dut_rec, e);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL flush_in_hold[%0d] res_valid=%b in_ready=%b required 0,1", c, res_valid, in_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid_window();
        rec_t e;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; prod_apx = W'($urandom); prod_ref = W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; prod_apx = 16'd1; prod_ref = 16'd0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        e = '{sum: 64'd4, mx: 64'd1, cnt: 64'd4, n: 64'd4, sq: SQ_EN ? 64'd4 : 64'd0};
        checks++;
        if (res_valid !== 1'b1 || dut_rec !== e) begin
            failures++;
            $display("FAIL rst_mid_window res_valid=%b rec=%h required 1,%h", res_valid, dut_rec, e);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_random();
        bit   m_hold = 1'b0;
        rec_t e = '0;
        logic [7:0] a, b;
        logic [W-1:0] exact;
        win_q.delete();
        for (int c = 0; c < 4000; c++) begin
            checks++;
            if (in_ready !== !m_hold || res_valid !== m_hold) begin
                failures++;
                $display("FAIL random_hs[%0d] in_ready=%b res_valid=%b required %b,%b", c, in_ready, res_valid, !m_hold, m_hold);
            end
            if (m_hold) begin
                checks++;
                if (dut_rec !== e) begin
                    failures++;
                    $display("FAIL random_rec[%0d] rec=%h required %h", c, dut_rec, e);
                end
            end
            a = 8'($urandom); b = 8'($urandom);
            exact = W'(a) * W'(b);
            case ($urandom_range(0, 3))
                0, 1:    prod_apx = exact;
                2:       prod_apx = exact ^ W'($urandom_range(0, 255));
                default: prod_apx = W'($urandom);
            endcase
            prod_ref  = exact;
            in_valid  = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            if (!m_hold) begin
                if (in_valid) win_q.push_back(abs_diff(prod_apx, prod_ref));
                if ((in_valid && win_q.size() == WIN) || flush) begin
                    e = summarize();
                    win_q.delete();
                    m_hold = 1'b1;
                end
            end else if (res_ready) begin
                m_hold = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_backpressure();
        test_flush();
        test_flush_coincident();
        test_rst_mid_window();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
